// File: rtl/alu_operand_stage_if.sv
// Bus between decode, the ID/EX operand stage, downstream forward sources and the ALU.
// The slave modport is the operand stage's view; master is the surrounding pipeline.
interface alu_operand_stage_if #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5
);
    logic                  stall;
    logic                  flush;
    logic                  id_valid;
    logic [REG_ADDR_W-1:0] id_rs1;
    logic [REG_ADDR_W-1:0] id_rs2;
    logic [REG_ADDR_W-1:0] id_rd;
    logic [XLEN-1:0]       id_rs1_data;
    logic [XLEN-1:0]       id_rs2_data;
    logic [XLEN-1:0]       id_imm;
    logic                  id_ALUSrc;
    logic [2:0]            id_ALUOp;
    logic                  id_RegWrite;
    logic                  id_MemRead;
    logic                  id_MemWrite;
    logic [REG_ADDR_W-1:0] mem_rd;
    logic                  mem_RegWrite;
    logic [XLEN-1:0]       mem_ALUResult;
    logic [REG_ADDR_W-1:0] wb_rd;
    logic                  wb_RegWrite;
    logic [XLEN-1:0]       wb_Result;
    logic [XLEN-1:0]       A;
    logic [XLEN-1:0]       B;
    logic [2:0]            ALUOp;
    logic                  ex_valid;
    logic [REG_ADDR_W-1:0] ex_rd;
    logic                  ex_RegWrite;
    logic                  ex_MemRead;
    logic                  ex_MemWrite;
    logic [XLEN-1:0]       ex_StoreData;
    logic                  load_use_stall;

    modport slave (
        input  stall, flush, id_valid, id_rs1, id_rs2, id_rd, id_rs1_data, id_rs2_data,
               id_imm, id_ALUSrc, id_ALUOp, id_RegWrite, id_MemRead, id_MemWrite,
               mem_rd, mem_RegWrite, mem_ALUResult, wb_rd, wb_RegWrite, wb_Result,
        output A, B, ALUOp, ex_valid, ex_rd, ex_RegWrite, ex_MemRead, ex_MemWrite,
               ex_StoreData, load_use_stall
    );

    modport master (
        output stall, flush, id_valid, id_rs1, id_rs2, id_rd, id_rs1_data, id_rs2_data,
               id_imm, id_ALUSrc, id_ALUOp, id_RegWrite, id_MemRead, id_MemWrite,
               mem_rd, mem_RegWrite, mem_ALUResult, wb_rd, wb_RegWrite, wb_Result,
        input  A, B, ALUOp, ex_valid, ex_rd, ex_RegWrite, ex_MemRead, ex_MemWrite,
               ex_StoreData, load_use_stall
    );
endinterface

// File: rtl/alu_operand_stage.sv
// ID/EX pipeline register with MEM/WB operand forwarding and load-use bubble insertion.
// Operands leave combinationally from the EX register plus same-cycle forwarding.
module alu_operand_stage #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5
) (
    input logic              clk,
    input logic              rst,
    alu_operand_stage_if.slave bus
);
    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rs1;
        logic [REG_ADDR_W-1:0] rs2;
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       rs1_data;
        logic [XLEN-1:0]       rs2_data;
        logic [XLEN-1:0]       imm;
        logic                  alu_src;
        logic [2:0]            alu_op;
        logic                  reg_write;
        logic                  mem_read;
        logic                  mem_write;
    } ex_reg_t;

    ex_reg_t         ex_q, ex_d;
    logic            load_use;
    logic [XLEN-1:0] rs1_fwd, rs2_fwd;

    // A load in EX feeding the decoded instruction cannot be forwarded in time.
    always_comb begin
        load_use = ex_q.valid & ex_q.mem_read & bus.id_valid & (ex_q.rd != '0) &
                   ((ex_q.rd == bus.id_rs1) | ((ex_q.rd == bus.id_rs2) & ~bus.id_ALUSrc));
    end

    always_comb begin
        ex_d = ex_q;
        if (bus.flush) begin
            ex_d = '0;
        end else if (bus.stall) begin
            ex_d = ex_q;
        end else if (load_use) begin
            ex_d = '0;
        end else begin
            ex_d.valid     = bus.id_valid;
            ex_d.rs1       = bus.id_rs1;
            ex_d.rs2       = bus.id_rs2;
            ex_d.rd        = bus.id_rd;
            ex_d.rs1_data  = bus.id_rs1_data;
            ex_d.rs2_data  = bus.id_rs2_data;
            ex_d.imm       = bus.id_imm;
            ex_d.alu_src   = bus.id_ALUSrc;
            ex_d.alu_op    = bus.id_ALUOp;
            ex_d.reg_write = bus.id_RegWrite;
            ex_d.mem_read  = bus.id_MemRead;
            ex_d.mem_write = bus.id_MemWrite;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) ex_q <= '0;
        else     ex_q <= ex_d;
    end

    // MEM is younger than WB, so it wins; x0 never forwards.
    always_comb begin
        rs1_fwd = ex_q.rs1_data;
        if (bus.mem_RegWrite && bus.mem_rd != '0 && bus.mem_rd == ex_q.rs1)
            rs1_fwd = bus.mem_ALUResult;
        else if (bus.wb_RegWrite && bus.wb_rd != '0 && bus.wb_rd == ex_q.rs1)
            rs1_fwd = bus.wb_Result;
        rs2_fwd = ex_q.rs2_data;
        if (bus.mem_RegWrite && bus.mem_rd != '0 && bus.mem_rd == ex_q.rs2)
            rs2_fwd = bus.mem_ALUResult;
        else if (bus.wb_RegWrite && bus.wb_rd != '0 && bus.wb_rd == ex_q.rs2)
            rs2_fwd = bus.wb_Result;
    end

    assign bus.A              = rs1_fwd;
    assign bus.B              = ex_q.alu_src ? ex_q.imm : rs2_fwd;
    assign bus.ex_StoreData   = rs2_fwd;
    assign bus.ALUOp          = ex_q.valid ? ex_q.alu_op : 3'b000;
    assign bus.ex_valid       = ex_q.valid;
    assign bus.ex_rd          = ex_q.rd;
    assign bus.ex_RegWrite    = ex_q.valid & ex_q.reg_write;
    assign bus.ex_MemRead     = ex_q.valid & ex_q.mem_read;
    assign bus.ex_MemWrite    = ex_q.valid & ex_q.mem_write;
    assign bus.load_use_stall = load_use;
endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed scenarios plus a randomized run against a record-level model of the EX stage.
module tb_alu_operand_stage;
    localparam int XLEN = 32;
    localparam int RW   = 5;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   pass_cnt = 0;
    int   total = 0;

    alu_operand_stage_if #(.XLEN(XLEN), .REG_ADDR_W(RW)) bus ();
    alu_operand_stage #(.XLEN(XLEN), .REG_ADDR_W(RW)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    typedef struct packed {
        logic            valid;
        logic [RW-1:0]   rs1, rs2, rd;
        logic [XLEN-1:0] d1, d2, imm;
        logic            src;
        logic [2:0]      op;
        logic            rw, mr, mw;
    } rec_t;

    rec_t m;

    function automatic logic model_lu();
        return m.valid && m.mr && bus.id_valid && m.rd != 0 &&
               (m.rd == bus.id_rs1 || (m.rd == bus.id_rs2 && !bus.id_ALUSrc));
    endfunction

    function automatic logic [XLEN-1:0] fwd(input logic [RW-1:0] r, input logic [XLEN-1:0] stored);
        if (r == 0) return stored;
        if (bus.mem_RegWrite && bus.mem_rd == r) return bus.mem_ALUResult;
        if (bus.wb_RegWrite && bus.wb_rd == r) return bus.wb_Result;
        return stored;
    endfunction

    task automatic tick();
        logic lu;
        lu = model_lu();
        if (rst || bus.flush) m = '0;
        else if (bus.stall) m = m;
        else if (lu) m = '0;
        else m = '{bus.id_valid, bus.id_rs1, bus.id_rs2, bus.id_rd, bus.id_rs1_data,
                   bus.id_rs2_data, bus.id_imm, bus.id_ALUSrc, bus.id_ALUOp,
                   bus.id_RegWrite, bus.id_MemRead, bus.id_MemWrite};
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [RW-1:0] r1, input logic [RW-1:0] r2,
                          input logic [RW-1:0] rd, input logic [XLEN-1:0] d1,
                          input logic [XLEN-1:0] d2, input logic [XLEN-1:0] imm,
                          input logic src, input logic [2:0] op,
                          input logic rwr, input logic mr, input logic mw);
        bus.id_valid = v; bus.id_rs1 = r1; bus.id_rs2 = r2; bus.id_rd = rd;
        bus.id_rs1_data = d1; bus.id_rs2_data = d2; bus.id_imm = imm;
        bus.id_ALUSrc = src; bus.id_ALUOp = op;
        bus.id_RegWrite = rwr; bus.id_MemRead = mr; bus.id_MemWrite = mw;
    endtask

    task automatic no_fwd();
        bus.mem_rd = 0; bus.mem_RegWrite = 0; bus.mem_ALUResult = 0;
        bus.wb_rd = 0; bus.wb_RegWrite = 0; bus.wb_Result = 0;
    endtask

    task automatic test_reset();
        bus.stall = 0; bus.flush = 0;
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        no_fwd();
        #1 rst = 1'b1;
        m = '0;
        #1;
        total++; if (bus.ex_valid !== 1'b0) $display("FAIL reset_valid got %b exp 0", bus.ex_valid); else pass_cnt++;
        total++; if (bus.ALUOp !== 3'b000) $display("FAIL reset_aluop got %b exp 000", bus.ALUOp); else pass_cnt++;
        tick();
        rst = 1'b0;
        set_id(1, 1, 2, 3, 32'd10, 32'd20, 0, 0, 3'b001, 1, 0, 0);
        tick();
        total++; if (bus.ex_valid !== 1'b1) $display("FAIL prereset_fill got %b exp 1", bus.ex_valid); else pass_cnt++;
        #2 rst = 1'b1;
        m = '0;
        #1;
        total++; if (bus.A !== '0 || bus.B !== '0) $display("FAIL async_reset_AB got %h/%h exp 0/0", bus.A, bus.B); else pass_cnt++;
        total++; if (bus.ALUOp !== 3'b000 || bus.ex_valid !== 1'b0 || bus.ex_RegWrite !== 1'b0)
            $display("FAIL async_reset_ctl got op=%b v=%b rw=%b exp 000/0/0", bus.ALUOp, bus.ex_valid, bus.ex_RegWrite); else pass_cnt++;
        total++; if (bus.ex_rd !== '0 || bus.ex_StoreData !== '0 || bus.load_use_stall !== 1'b0)
            $display("FAIL async_reset_misc got rd=%0d sd=%h lu=%b exp 0/0/0", bus.ex_rd, bus.ex_StoreData, bus.load_use_stall); else pass_cnt++;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_capture();
        no_fwd();
        set_id(1, 1, 2, 5, 32'd10, 32'd5, 0, 0, 3'b000, 1, 0, 0);
        tick();
        total++; if (bus.A !== 32'd10 || bus.B !== 32'd5) $display("FAIL capture_AB got %0d/%0d exp 10/5", bus.A, bus.B); else pass_cnt++;
        total++; if (bus.ALUOp !== 3'b000 || bus.ex_valid !== 1'b1 || bus.ex_rd !== 5'd5 || bus.ex_RegWrite !== 1'b1)
            $display("FAIL capture_ctl got op=%b v=%b rd=%0d rw=%b exp 000/1/5/1", bus.ALUOp, bus.ex_valid, bus.ex_rd, bus.ex_RegWrite); else pass_cnt++;
    endtask

    task automatic test_forward_priority();
        no_fwd();
        set_id(1, 3, 0, 8, 32'd100, 32'd0, 0, 0, 3'b011, 1, 0, 0);
        tick();
        bus.mem_rd = 3; bus.mem_RegWrite = 1; bus.mem_ALUResult = 32'hFFFF_FFFB;
        bus.wb_rd = 3; bus.wb_RegWrite = 1; bus.wb_Result = 32'd7;
        #1;
        total++; if (bus.A !== 32'hFFFF_FFFB) $display("FAIL fwd_mem_prio got %h exp fffffffb", bus.A); else pass_cnt++;
        total++; if (bus.ALUOp !== 3'b011) $display("FAIL fwd_aluop got %b exp 011", bus.ALUOp); else pass_cnt++;
        bus.mem_RegWrite = 0;
        #1;
        total++; if (bus.A !== 32'd7) $display("FAIL fwd_wb got %h exp 7", bus.A); else pass_cnt++;
        bus.wb_RegWrite = 0;
        #1;
        total++; if (bus.A !== 32'd100) $display("FAIL fwd_none got %h exp 100", bus.A); else pass_cnt++;
        set_id(1, 0, 0, 8, 32'd0, 32'd0, 0, 0, 3'b000, 1, 0, 0);
        tick();
        bus.mem_rd = 0; bus.mem_RegWrite = 1; bus.mem_ALUResult = 32'hDEAD;
        bus.wb_rd = 0; bus.wb_RegWrite = 1; bus.wb_Result = 32'hBEEF;
        #1;
        total++; if (bus.A !== 32'd0 || bus.B !== 32'd0) $display("FAIL fwd_x0 got %h/%h exp 0/0", bus.A, bus.B); else pass_cnt++;
    endtask

    task automatic test_imm_store();
        no_fwd();
        set_id(1, 1, 6, 7, 32'd0, 32'd99, 32'd3, 1, 3'b000, 0, 0, 1);
        tick();
        bus.wb_rd = 6; bus.wb_RegWrite = 1; bus.wb_Result = 32'd15;
        #1;
        total++; if (bus.B !== 32'd3) $display("FAIL imm_B got %0d exp 3", bus.B); else pass_cnt++;
        total++; if (bus.ex_StoreData !== 32'd15 || bus.ex_MemWrite !== 1'b1)
            $display("FAIL store_data got %0d mw=%b exp 15/1", bus.ex_StoreData, bus.ex_MemWrite); else pass_cnt++;
    endtask

    task automatic test_load_use();
        no_fwd();
        set_id(1, 1, 0, 4, 32'd0, 32'd0, 32'd8, 1, 3'b000, 1, 1, 0);
        tick();
        set_id(1, 4, 2, 5, 32'd111, 32'd22, 0, 0, 3'b000, 1, 0, 0);
        #1;
        total++; if (bus.load_use_stall !== 1'b1) $display("FAIL lu_detect got %b exp 1", bus.load_use_stall); else pass_cnt++;
        tick();
        total++; if (bus.ex_valid !== 1'b0 || bus.ALUOp !== 3'b000 || bus.load_use_stall !== 1'b0)
            $display("FAIL lu_bubble got v=%b op=%b lu=%b exp 0/000/0", bus.ex_valid, bus.ALUOp, bus.load_use_stall); else pass_cnt++;
        bus.mem_rd = 4; bus.mem_RegWrite = 1; bus.mem_ALUResult = 32'h1234;
        tick();
        total++; if (bus.ex_valid !== 1'b1 || bus.A !== 32'h1234 || bus.B !== 32'd22)
            $display("FAIL lu_release got v=%b A=%h B=%h exp 1/1234/16", bus.ex_valid, bus.A, bus.B); else pass_cnt++;
        no_fwd();
        set_id(1, 1, 0, 4, 32'd0, 32'd0, 32'd8, 1, 3'b000, 1, 1, 0);
        tick();
        set_id(1, 1, 4, 5, 32'd0, 32'd0, 32'd1, 1, 3'b000, 1, 0, 0);
        #1;
        total++; if (bus.load_use_stall !== 1'b0) $display("FAIL lu_imm_rs2 got %b exp 0", bus.load_use_stall); else pass_cnt++;
        set_id(1, 1, 0, 0, 32'd0, 32'd0, 32'd8, 1, 3'b000, 1, 1, 0);
        tick();
        set_id(1, 0, 0, 5, 32'd0, 32'd0, 32'd0, 0, 3'b000, 1, 0, 0);
        #1;
        total++; if (bus.load_use_stall !== 1'b0) $display("FAIL lu_x0 got %b exp 0", bus.load_use_stall); else pass_cnt++;
    endtask

    task automatic test_flush_stall();
        logic [XLEN-1:0] a0, b0;
        no_fwd();
        set_id(1, 1, 2, 9, 32'd50, 32'd60, 0, 0, 3'b011, 1, 0, 0);
        tick();
        bus.flush = 1; bus.stall = 1;
        set_id(1, 3, 4, 10, 32'd1, 32'd2, 0, 0, 3'b010, 1, 0, 0);
        tick();
        total++; if (bus.ex_valid !== 1'b0 || bus.ex_RegWrite !== 1'b0 || bus.ALUOp !== 3'b000)
            $display("FAIL flush_over_stall got v=%b rw=%b op=%b exp 0/0/000", bus.ex_valid, bus.ex_RegWrite, bus.ALUOp); else pass_cnt++;
        bus.flush = 0; bus.stall = 0;
        set_id(1, 1, 2, 9, 32'd50, 32'd60, 0, 0, 3'b100, 1, 0, 0);
        tick();
        a0 = bus.A; b0 = bus.B;
        total++; if (a0 !== 32'd50 || b0 !== 32'd60) $display("FAIL stall_prefill got %0d/%0d exp 50/60", a0, b0); else pass_cnt++;
        bus.stall = 1;
        for (int i = 0; i < 3; i++) begin
            set_id(1, 5 + i[4:0], 6, 11, 32'd7 + i, 32'd8, 32'd9, 1, 3'b001, 0, 1, 1);
            tick();
            total++;
            if (bus.A !== 32'd50 || bus.B !== 32'd60 || bus.ALUOp !== 3'b100 || bus.ex_valid !== 1'b1 || bus.ex_rd !== 5'd9 || bus.ex_MemWrite !== 1'b0)
                $display("FAIL stall_hold_%0d got A=%0d B=%0d op=%b v=%b rd=%0d exp 50/60/100/1/9", i, bus.A, bus.B, bus.ALUOp, bus.ex_valid, bus.ex_rd);
            else pass_cnt++;
        end
        bus.stall = 0;
        set_id(1, 1, 0, 4, 32'd0, 32'd0, 32'd8, 1, 3'b000, 1, 1, 0);
        tick();
        bus.stall = 1;
        set_id(1, 4, 0, 5, 32'd0, 32'd0, 32'd0, 1, 3'b000, 1, 0, 0);
        tick();
        total++; if (bus.ex_valid !== 1'b1 || bus.ex_MemRead !== 1'b1 || bus.ex_rd !== 5'd4 || bus.load_use_stall !== 1'b1)
            $display("FAIL stall_lu_hold got v=%b mr=%b rd=%0d lu=%b exp 1/1/4/1", bus.ex_valid, bus.ex_MemRead, bus.ex_rd, bus.load_use_stall); else pass_cnt++;
        bus.stall = 0;
    endtask

    task automatic test_random();
        int errs;
        errs = 0;
        for (int i = 0; i < 400; i++) begin
            set_id($urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                   $urandom, $urandom, $urandom, $urandom_range(0, 1), $urandom_range(0, 4),
                   $urandom_range(0, 1), $urandom_range(0, 2) == 0, $urandom_range(0, 1));
            bus.stall = ($urandom_range(0, 7) == 0);
            bus.flush = ($urandom_range(0, 9) == 0);
            tick();
            bus.mem_rd = $urandom_range(0, 7); bus.mem_RegWrite = $urandom_range(0, 1); bus.mem_ALUResult = $urandom;
            bus.wb_rd = $urandom_range(0, 7); bus.wb_RegWrite = $urandom_range(0, 1); bus.wb_Result = $urandom;
            #1;
            total++;
            if (bus.A !== fwd(m.rs1, m.d1) || bus.B !== (m.src ? m.imm : fwd(m.rs2, m.d2)) ||
                bus.ex_StoreData !== fwd(m.rs2, m.d2) || bus.ALUOp !== (m.valid ? m.op : 3'b000) ||
                bus.ex_valid !== m.valid || bus.ex_rd !== m.rd || bus.ex_RegWrite !== (m.valid & m.rw) ||
                bus.ex_MemRead !== (m.valid & m.mr) || bus.ex_MemWrite !== (m.valid & m.mw) ||
                bus.load_use_stall !== model_lu()) begin
                errs++;
                if (errs <= 5)
                    $display("FAIL random_%0d got A=%h B=%h sd=%h op=%b v=%b rd=%0d lu=%b exp A=%h B=%h sd=%h op=%b v=%b rd=%0d lu=%b",
                             i, bus.A, bus.B, bus.ex_StoreData, bus.ALUOp, bus.ex_valid, bus.ex_rd, bus.load_use_stall,
                             fwd(m.rs1, m.d1), m.src ? m.imm : fwd(m.rs2, m.d2), fwd(m.rs2, m.d2),
                             m.valid ? m.op : 3'b000, m.valid, m.rd, model_lu());
            end else pass_cnt++;
        end
        bus.stall = 0; bus.flush = 0;
    endtask

    initial begin
        test_reset();
        test_capture();
        test_forward_priority();
        test_imm_store();
        test_load_use();
        test_flush_stall();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule

// File: doc/alu_operand_stage.md
Name: alu_operand_stage

Overview:
- ID/EX pipeline register plus operand-forwarding network, directly upstream of the ALU.
- Captures decoded operands and control each cycle.
- Resolves RAW hazards by forwarding from the MEM and WB stages.
- Drives the ALU's A, B and ALUOp inputs.
- Detects load-use hazards and inserts bubbles; the upstream fetch/decode stages are told to hold.

Parameters:
- XLEN, 32, datapath width of operands, immediate and results.
- REG_ADDR_W, 5, register index width.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- stall  input  1  global hold; the EX register keeps its contents.
- flush  input  1  kill the instruction entering EX (branch taken).
- id_valid  input  1  decode stage holds a real instruction.
- id_rs1, id_rs2, id_rd  input  REG_ADDR_W  register indices.
- id_rs1_data, id_rs2_data  input  XLEN  register-file read data.
- id_imm  input  XLEN  sign-extended immediate.
- id_ALUSrc  input  1  1: B = immediate; 0: B = forwarded rs2.
- id_ALUOp  input  3  000 add, 001 sub, 010 and, 011 or, 100 slt.
- id_RegWrite, id_MemRead, id_MemWrite  input  1  control bits.
- mem_rd  input  REG_ADDR_W  destination of the instruction in MEM.
- mem_RegWrite  input  1  write enable of the instruction in MEM.
- mem_ALUResult  input  XLEN  forward source 1.
- wb_rd  input  REG_ADDR_W  destination of the instruction in WB.
- wb_RegWrite  input  1  write enable of the instruction in WB.
- wb_Result  input  XLEN  forward source 2.
- A, B  output  XLEN  ALU operands (combinational from EX register plus forwarding).
- ALUOp  output  3  registered; 000 when ex_valid=0.
- ex_valid  output  1  EX holds a real instruction.
- ex_rd  output  REG_ADDR_W  registered destination index.
- ex_RegWrite, ex_MemRead, ex_MemWrite  output  1  registered control bits, gated by ex_valid.
- ex_StoreData  output  XLEN  forwarded rs2 value (for stores).
- load_use_stall  output  1  combinational; upstream must hold PC and IF/ID when high.

Behaviour:
- Reset: asynchronous; all EX fields clear immediately on rst=1, independent of clk.
  - Fields cleared: valid, rs1/rs2/rd, data, imm, ALUSrc, ALUOp, control bits.
  - Result: A=B=0, ALUOp=000, ex_valid=0, ex_rd=0, all ex_* controls=0, ex_StoreData=0, load_use_stall=0.
- Hazard detect: load_use_stall = ex_valid & ex_MemRead & id_valid & (ex_rd!=0) & (ex_rd==id_rs1 | (ex_rd==id_rs2 & !id_ALUSrc)).
- Update on rising edge, in priority order:
  1. flush: load a bubble (all fields zero).
  2. stall: hold all fields.
  3. load_use_stall: load a bubble.
  4. Otherwise: capture all id_* inputs; ex_valid <= id_valid.
- Bubble = all fields zero. The instruction held upstream re-enters EX on the next unstalled edge.
- Forwarding for rs1 (combinational):
  - If mem_RegWrite & mem_rd!=0 & mem_rd==ex_rs1: use mem_ALUResult.
  - Else if wb_RegWrite & wb_rd!=0 & wb_rd==ex_rs1: use wb_Result.
  - Else: use the stored rs1 data.
- Forwarding for rs2: same rules. MEM has priority over WB when both match.
- Register x0 is never forwarded; reads of x0 use stored data (0 from the register file).
- A = forwarded rs1.
- B = ex_ALUSrc ? ex_imm : forwarded rs2.
- ex_StoreData = forwarded rs2, always, regardless of ALUSrc.
- Latency: one cycle from id_* to A/B/ALUOp. Forwarding is zero-cycle (same-cycle combinational).
- Simultaneous events:
  - flush+stall: flush wins.
  - stall+load_use: hold; no bubble, since the EX contents are unchanged and still hazardous.
  - rst overrides all.
- Mid-operation reset: the in-flight EX instruction is discarded. The first post-reset edge captures normally.
- Widths: no arithmetic in this block. All data paths are XLEN; no truncation or extension.

Test Plan:
- Reset: assert rst asynchronously mid-cycle with EX full -> A=0, B=0, ALUOp=000, ex_valid=0 before the next edge.
- Plain capture: id_rs1_data=10, id_rs2_data=5, ALUSrc=0, ALUOp=000, no forward matches -> after 1 edge A=10, B=5, ALUOp=000, ex_valid=1.
- Forward priority: ex_rs1=3; mem_rd=3, mem_RegWrite=1, mem_ALUResult=-5; wb_rd=3, wb_RegWrite=1, wb_Result=7 -> A=-5. Drop mem_RegWrite -> A=7. Set mem_rd=0 with ex_rs1=0 -> A=stored 0.
- Immediate/store: ALUSrc=1, imm=3, rs2 forwarded from WB with value 15 -> B=3, ex_StoreData=15.
- Load-use: EX holds lw to x4 (MemRead=1); ID is add with rs1=x4 -> load_use_stall=1, next edge ex_valid=0, ALUOp=000. Release -> the add is captured and A forwards from MEM.
- Flush vs stall: flush=1 and stall=1 with EX full -> next edge ex_valid=0, ex_RegWrite=0. stall alone -> all outputs unchanged for 3 cycles.
